// File: rtl/imem_if.sv
// Instruction-memory request/response channel: one outstanding request,
// req/ready handshake for the address, rvalid pulse for the returned word.
interface imem_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rvalid, input rdata);
   modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding memory fetch,
// held instruction for decode, and branch redirect with wrong-path kill.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrc,
   input  logic [31:0] PCTarget,
   input  logic        stall,
   input  logic        decode_ready,
   imem_if.master      imem,
   output logic        instr_valid,
   output logic [31:0] Instr,
   output logic [31:0] PC_out,
   output logic [31:0] PCPlus4,
   output logic [6:0]  Op,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] addr_r;
   logic [31:0] instr_r;
   logic [31:0] pc_out_r;
   logic        kill_r;
   logic        req_r;
   logic        valid_r;
   logic        misalign_r;

   logic        handshake_s;
   logic        consume_s;
   logic [31:0] target_s;
   logic [31:0] next_pc_s;

   assign handshake_s = req_r & imem.ready;
   assign consume_s   = decode_ready & ~stall;
   assign target_s    = {PCTarget[31:2], 2'b00};
   // Address of the next request issued: a redirect this cycle takes effect at once.
   assign next_pc_s   = PCSrc ? target_s : pc_r;

   // Fetch FSM with PC, kill flag, request and held-instruction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_IDLE;
         pc_r       <= RESET_PC;
         addr_r     <= RESET_PC;
         instr_r    <= NOP_INSTR;
         pc_out_r   <= RESET_PC;
         kill_r     <= 1'b0;
         req_r      <= 1'b0;
         valid_r    <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         if (PCSrc) begin
            pc_r <= target_s;
            if (PCTarget[1:0] != 2'b00) begin
               misalign_r <= 1'b1;
            end
         end
         case (state_r)
            S_IDLE: begin
               state_r <= S_REQ;
               req_r   <= 1'b1;
               addr_r  <= next_pc_s;
            end
            S_REQ: begin
               // The pending address stays put until granted; a redirect only marks it for discard.
               if (handshake_s) begin
                  state_r <= S_WAIT;
                  req_r   <= 1'b0;
               end
               if (PCSrc) begin
                  kill_r <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem.rvalid) begin
                  if (kill_r || PCSrc) begin
                     kill_r  <= 1'b0;
                     state_r <= S_REQ;
                     req_r   <= 1'b1;
                     addr_r  <= next_pc_s;
                  end else begin
                     instr_r  <= imem.rdata;
                     pc_out_r <= pc_r;
                     pc_r     <= pc_r + 32'd4;
                     valid_r  <= 1'b1;
                     state_r  <= S_HOLD;
                  end
               end else if (PCSrc) begin
                  kill_r <= 1'b1;
               end
            end
            S_HOLD: begin
               if (PCSrc || consume_s) begin
                  valid_r <= 1'b0;
                  instr_r <= NOP_INSTR;
                  state_r <= S_REQ;
                  req_r   <= 1'b1;
                  addr_r  <= next_pc_s;
               end
            end
            default: begin
               state_r <= S_IDLE;
               req_r   <= 1'b0;
               valid_r <= 1'b0;
               instr_r <= NOP_INSTR;
               kill_r  <= 1'b0;
            end
         endcase
      end
   end

   assign imem.req     = req_r;
   assign imem.addr    = addr_r;
   assign instr_valid  = valid_r;
   assign Instr        = instr_r;
   assign PC_out       = pc_out_r;
   assign PCPlus4      = pc_out_r + 32'd4;
   assign Op           = instr_r[6:0];
   assign funct3       = instr_r[14:12];
   assign funct7       = instr_r[31:25];
   assign misalign_err = misalign_r;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the control/decode logic. Holds the PC and issues one outstanding request at a time to instruction memory over a req/ready, rvalid handshake. Registers the returned instruction and presents Op/funct3/funct7 plus the full word to decode. Applies branch redirects (PCSrc/PCTarget), discarding any in-flight fetch from the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, value of Instr while no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
PCSrc  input  1  redirect pulse from control unit (branch taken)
PCTarget  input  32  redirect target, sampled when PCSrc=1
stall  input  1  downstream hold; blocks consumption of the held instruction
decode_ready  input  1  decode accepts Instr this cycle
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  memory accepts request (handshake = imem_req & imem_ready)
imem_rvalid  input  1  read data valid, one pulse per accepted request, ≥1 cycle after handshake
imem_rdata  input  32  instruction word
instr_valid  output  1  Instr/PC_out hold a valid instruction
Instr  output  32  registered instruction
PC_out  output  32  address of Instr
PCPlus4  output  32  PC_out + 4
Op  output  7  Instr[6:0]
funct3  output  3  Instr[14:12]
funct7  output  7  Instr[31:25]
misalign_err  output  1  sticky: a redirect target had bits [1:0] ≠ 0

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=NOP_INSTR, PC_out=RESET_PC, misalign_err=0. Op/funct3/funct7/PCPlus4 follow combinationally.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release; go to REQ.
- REQ: imem_req=1, imem_addr=pc. imem_addr stays stable while imem_req=1 and imem_ready=0. On handshake, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - if kill=1: discard data, clear kill, go to REQ;
  - else: Instr<=imem_rdata, PC_out<=pc, pc<=pc+4, instr_valid<=1, go to HOLD.
- HOLD: instr_valid=1. Consume = decode_ready & ~stall. On consume: instr_valid<=0, Instr<=NOP_INSTR, go to REQ. Otherwise hold all outputs unchanged.
- Best-case throughput with imem_ready=1 and rvalid one cycle after handshake: one instruction per 3 cycles. Consume at t, handshake at t+1, rvalid at t+2, instr_valid at t+3.
- Redirect (PCSrc=1), highest priority over all normal updates:
  - pc <= {PCTarget[31:2],2'b00}; if PCTarget[1:0] ≠ 0, misalign_err <= 1 (sticky until reset).
  - IDLE: pc is updated; flow continues normally.
  - HOLD: instr_valid<=0, Instr<=NOP_INSTR, go to REQ. The held instruction is dropped even if consumed the same cycle.
  - REQ, no handshake this cycle: stay in REQ. The old address remains until granted, per the stability rule; set kill. imem_addr switches to the target on the next request after the killed one.
  - REQ with handshake this cycle: go to WAIT with kill=1.
  - WAIT (including the cycle where imem_rvalid=1): kill=1. If rvalid is coincident, the data is discarded and the state goes to REQ with the new pc. Otherwise the next rvalid is discarded.
  - Back-to-back redirects: the last target wins; kill stays 1.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. PCPlus4 wraps the same way.
- imem_rvalid outside WAIT is ignored.

Test Plan:
- Reset and first fetch: release rst; memory with ready=1 and rvalid one cycle later returns 32'h0050_0093 at 0 → imem_req at cycle 1 with addr 0; instr_valid=1 at cycle 3; Op=7'h13, funct3=0, PC_out=0, PCPlus4=4.
- Stall/backpressure: hold stall=1 for 5 cycles in HOLD → Instr, PC_out, and instr_valid stay constant and imem_req=0; release → next fetch addr 4.
- Redirect in WAIT: PCSrc=1, PCTarget=32'h40 while awaiting the response for addr 8 → that response is discarded (instr_valid stays 0); next request addr 32'h40; PC_out=32'h40 when valid.
- Redirect during ungranted REQ: imem_ready=0 at addr 12, PCSrc with target 32'h80 → addr stays 12 until granted; the response is discarded; next request addr 32'h80.
- Misaligned target and wrap: PCTarget=32'hFFFF_FFFE → misalign_err=1, fetch addr 32'hFFFF_FFFC, PCPlus4=0, next fetch addr 0; misalign_err stays 1 until rst=0.
- Async reset mid-WAIT: assert rst between clock edges → outputs immediately return to reset values; a late rvalid after release is ignored; the first request goes to RESET_PC.
